seq_divider: RTL

- Self-sequenced, parametrised restoring divider: shift-subtract, one quotient bit per clock.
- Replaces the externally sequenced divisor/remainder/quotient/compare datapath with an internal FSM and a start/busy/done handshake.
- Adds WIDTH generalisation, a per-operation signed mode and divide-by-zero reporting.
- Sits beside the ALU as a multi-cycle functional unit.

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_step.sv | 27 ++
 rtl/seq_divider.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types, constants and width-generic helpers for the sequential divider.
package div_pkg;

    // Widest operand the helper functions can handle.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quotient reported for a zero divisor; callers truncate to their width.
    localparam logic [MAX_W-1:0] DZ_QUOTIENT = '1;

    // Mask with the low w bits set.
    function automatic logic [MAX_W-1:0] width_mask(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

    // Two's-complement negation of the low w bits of x.
    function automatic logic [MAX_W-1:0] neg(input logic [MAX_W-1:0] x, input int w);
        return (~x + MAX_W'(1)) & width_mask(w);
    endfunction

    // Magnitude of a w-bit two's-complement value; the most-negative value
    // comes back as its unsigned bit pattern (e.g. 0x80 for w = 8).
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x, input int w);
        return x[w-1] ? neg(x, w) : (x & width_mask(w));
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    localparam int RW = WIDTH + 1;

    logic [WIDTH+1:0] trial;
    logic [WIDTH+2:0] diff;

    // Trial subtraction; the borrow out of the extra top bit decides the quotient bit.
    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        trial   = {rem_in, bit_in};
        diff    = {1'b0, trial} - {3'b000, divisor};
        q_bit   = ~diff[WIDTH+2];
        rem_out = RW'(q_bit ? diff[WIDTH+1:0] : trial);
    end

endmodule

// File: rtl/seq_divider.sv
// Self-sequenced restoring divider: start/busy/done handshake, one quotient
// bit per clock, optional two's-complement mode, divide-by-zero reporting.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] din_N,
    input  logic [WIDTH-1:0] din_D,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout_Q,
    output logic [WIDTH-1:0] dout_R,
    output logic             div_zero
);

    state_t state;
    state_t state_nxt;

    // Iteration registers.
    logic [WIDTH-1:0] dvd;     // dividend magnitude, consumed MSB first
    logic [WIDTH-1:0] dvs;     // divisor magnitude
    logic [WIDTH:0]   prem;    // partial remainder
    logic [WIDTH-1:0] quo;     // quotient bits collected so far
    logic [CNT_W-1:0] cnt;     // iterations left
    logic             neg_q;   // negate quotient at the end
    logic             neg_r;   // negate remainder at the end

    // Start-time decode.
    logic             accept;
    logic             dvs_zero;
    logic             n_neg;
    logic             d_neg;
    logic [WIDTH-1:0] mag_n;
    logic [WIDTH-1:0] mag_d;

    // Step outputs and the assembled unsigned results.
    logic [WIDTH:0]   rem_nxt;
    logic             q_bit;
    logic             last;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    assign accept   = start && (state != RUN);
    assign dvs_zero = (din_D == '0);
    assign n_neg    = is_signed & din_N[WIDTH-1];
    assign d_neg    = is_signed & din_D[WIDTH-1];
    assign mag_n    = is_signed ? WIDTH'(abs_val(MAX_W'(din_N), WIDTH)) : din_N;
    assign mag_d    = is_signed ? WIDTH'(abs_val(MAX_W'(din_D), WIDTH)) : din_D;
    assign last     = (cnt == CNT_W'(1));
    assign q_final  = WIDTH'({quo, q_bit});
    assign r_final  = WIDTH'(rem_nxt);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (prem),
        .bit_in  (dvd[WIDTH-1]),
        .divisor (dvs),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a zero divisor skips RUN; DONE re-accepts start immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = dvs_zero ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state, so reset clears them at once.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand capture, iteration and result registers.
    // NOTE: all datapath registers are reset because an aborted operation must leave no stale state visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd      <= '0;
            dvs      <= '0;
            prem     <= '0;
            quo      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dout_Q   <= '0;
            dout_R   <= '0;
            div_zero <= 1'b0;
        end else if (accept) begin
            if (dvs_zero) begin
                dout_Q   <= WIDTH'(DZ_QUOTIENT);
                dout_R   <= din_N;
                div_zero <= 1'b1;
            end else begin
                dvd      <= mag_n;
                dvs      <= mag_d;
                prem     <= '0;
                quo      <= '0;
                cnt      <= CNT_W'(WIDTH);
                neg_q    <= n_neg ^ d_neg;
                neg_r    <= n_neg;
                div_zero <= 1'b0;
            end
        end else if (state == RUN) begin
            dvd  <= dvd << 1;
            prem <= rem_nxt;
            quo  <= q_final;
            cnt  <= cnt - CNT_W'(1);
            if (last) begin
                // Negating zero yields zero, so a zero Q or R never changes sign.
                dout_Q <= neg_q ? WIDTH'(neg(MAX_W'(q_final), WIDTH)) : q_final;
                dout_R <= neg_r ? WIDTH'(neg(MAX_W'(r_final), WIDTH)) : r_final;
            end
        end
    end

endmodule
